aes_reseed_ctrl: RTL and testbench

AES_RESEED_CTRL -- requirements
Module: aes_reseed_ctrl

---
 rtl/aes_reseed_ctrl.sv | 112 +++++++++++
 tb/tb_aes_reseed_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_reseed_ctrl.sv
// Purpose: gates user encryptions to the masked AES core and forces a PRNG reseed after MAX_ENC accepts.
// Latency: zero; all handshakes are combinational pass-throughs selected by the FSM state.
// Backpressure: in_ready follows core_in_ready in RUN only; src_seed_ready follows core_seed_ready in SEED only.
// Build option: define AES_RESEED_FORCE_EN to add the force_reseed input (early reseed request).
module aes_reseed_ctrl #(
   parameter  int MAX_ENC = 1024,
   localparam int CW      = $clog2(MAX_ENC + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          core_in_valid,
   input  logic          core_in_ready,
   input  logic          core_busy,
   input  logic          src_seed_valid,
   output logic          src_seed_ready,
   input  logic [79:0]   src_seed,
   output logic          core_seed_valid,
   input  logic          core_seed_ready,
   output logic [79:0]   core_seed,
`ifdef AES_RESEED_FORCE_EN
   input  logic          force_reseed,
`endif
   output logic          need_reseed,
   output logic [CW-1:0] enc_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SEED  = 2'd2
   } state_t;

   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_ENC);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_ENC - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count_nxt;
   logic          accept;
   logic          seed_hs;
   logic          force_req;

`ifdef AES_RESEED_FORCE_EN
   assign force_req = force_reseed;
`else
   assign force_req = 1'b0;
`endif

   // Seed data is a pure wire; only its valid is qualified by the state.
   assign core_seed = src_seed;

   // Next-state, counter update and handshake steering for the current state.
   always_comb begin
      state_nxt       = state;
      count_nxt       = enc_count;
      in_ready        = 1'b0;
      core_in_valid   = 1'b0;
      src_seed_ready  = 1'b0;
      core_seed_valid = 1'b0;
      need_reseed     = 1'b1;
      accept          = 1'b0;
      seed_hs         = 1'b0;
      case (state)
         RUN: begin
            need_reseed   = 1'b0;
            core_in_valid = in_valid;
            in_ready      = core_in_ready;
            accept        = in_valid & core_in_ready;
            // Saturate rather than wrap; the budget check below leaves RUN first anyway.
            if (accept && (enc_count != MAX_CNT)) begin
               count_nxt = enc_count + CW'(1);
            end
            if ((accept && (enc_count == LAST_CNT)) || (enc_count == MAX_CNT) || force_req) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Wait for the core to finish in-flight work before swapping masks.
            if (!core_busy) begin
               state_nxt = SEED;
            end
         end
         SEED: begin
            core_seed_valid = src_seed_valid;
            src_seed_ready  = core_seed_ready;
            seed_hs         = src_seed_valid & core_seed_ready;
            if (seed_hs) begin
               state_nxt = RUN;
               count_nxt = '0;
            end
         end
         default: begin
            state_nxt = SEED;
            count_nxt = '0;
         end
      endcase
   end

   // State and budget counter; reset parks in SEED so nothing runs unseeded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEED;
         enc_count <= '0;
      end else begin
         state     <= state_nxt;
         enc_count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_aes_reseed_ctrl.sv
// Directed bench for aes_reseed_ctrl with MAX_ENC = 3.
// A monitor pops expected accept counts and seed words whenever the DUT completes a handshake.
module tb_aes_reseed_ctrl;
   localparam int MAX_ENC = 3;
   localparam int CW      = $clog2(MAX_ENC + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          core_in_valid;
   logic          core_in_ready;
   logic          core_busy;
   logic          src_seed_valid;
   logic          src_seed_ready;
   logic [79:0]   src_seed;
   logic          core_seed_valid;
   logic          core_seed_ready;
   logic [79:0]   core_seed;
   logic          need_reseed;
   logic [CW-1:0] enc_count;
`ifdef AES_RESEED_FORCE_EN
   logic          force_reseed;
`endif

   int          checks = 0;
   int          errors = 0;
   int          bad;
   logic [79:0] seed_q[$];
   int          acc_q[$];

   always #5 clk = ~clk;

   aes_reseed_ctrl #(.MAX_ENC(MAX_ENC)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .core_in_valid   (core_in_valid),
      .core_in_ready   (core_in_ready),
      .core_busy       (core_busy),
      .src_seed_valid  (src_seed_valid),
      .src_seed_ready  (src_seed_ready),
      .src_seed        (src_seed),
      .core_seed_valid (core_seed_valid),
      .core_seed_ready (core_seed_ready),
      .core_seed       (core_seed),
`ifdef AES_RESEED_FORCE_EN
      .force_reseed    (force_reseed),
`endif
      .need_reseed     (need_reseed),
      .enc_count       (enc_count)
   );

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sample point: falling edge, where inputs have been stable since posedge+1.
   task automatic mid();
      @(negedge clk);
   endtask

   // Drive point: just after the rising edge.
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every completed handshake must match the next expectation.
   always @(negedge clk) begin
      if (core_in_valid && core_in_ready) begin
         if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_unexpected: accept at enc_count=%0d, none expected", enc_count);
         end else begin
            chk("accept_count", 80'(enc_count), 80'(acc_q.pop_front()));
         end
      end
      if (core_seed_valid && core_seed_ready) begin
         if (seed_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL seed_unexpected: seed %0h presented, none expected", core_seed);
         end else begin
            chk("seed_data", core_seed, seed_q.pop_front());
         end
      end
   end

   // Deliver one seed with no stall and confirm the return to RUN with a zero count.
   task automatic do_seed(input logic [79:0] val);
      seed_q.push_back(val);
      src_seed        = val;
      src_seed_valid  = 1'b1;
      core_seed_ready = 1'b1;
      in_valid        = 1'b0;
      mid();
      adv();
      src_seed_valid = 1'b0;
      mid();
      chk("reseed_run", need_reseed, 1'b0);
      chk("reseed_count", 80'(enc_count), 80'd0);
      adv();
   endtask

   initial begin
      rst             = 1'b1;
      in_valid        = 1'b1;
      core_in_ready   = 1'b1;
      core_busy       = 1'b0;
      src_seed_valid  = 1'b0;
      src_seed        = 80'h0;
      core_seed_ready = 1'b1;
`ifdef AES_RESEED_FORCE_EN
      force_reseed    = 1'b0;
`endif
      adv();
      adv();
      mid();
      chk("rst_need_reseed", need_reseed, 1'b1);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_core_in_valid", core_in_valid, 1'b0);
      chk("rst_core_seed_valid", core_seed_valid, 1'b0);
      chk("rst_src_seed_ready", src_seed_ready, 1'b1);
      chk("rst_enc_count", 80'(enc_count), 80'd0);
      adv();
      rst = 1'b0;

      // Requests held with no seed must stay blocked.
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         mid();
         if (in_ready !== 1'b0 || need_reseed !== 1'b1 || core_in_valid !== 1'b0) bad++;
         adv();
      end
      chk("blocked_before_seed", 80'(bad), 80'd0);
      do_seed(80'h1234);

      // RUN pass-through, no accept in either cycle.
      in_valid      = 1'b1;
      core_in_ready = 1'b0;
      mid();
      chk("run_valid_pass", core_in_valid, 1'b1);
      chk("run_ready_pass_lo", in_ready, 1'b0);
      adv();
      in_valid      = 1'b0;
      core_in_ready = 1'b1;
      mid();
      chk("run_ready_pass_hi", in_ready, 1'b1);
      chk("run_valid_lo", core_in_valid, 1'b0);
      chk("run_count_hold", 80'(enc_count), 80'd0);
      adv();

      // Budget exhaustion with an idle core: one DRAIN cycle then SEED.
      acc_q.push_back(0); acc_q.push_back(1); acc_q.push_back(2);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid();
         adv();
      end
      mid();
      chk("budget_count", 80'(enc_count), 80'd3);
      chk("drain_need_reseed", need_reseed, 1'b1);
      chk("drain_in_ready", in_ready, 1'b0);
      chk("drain_core_in_valid", core_in_valid, 1'b0);
      chk("drain_src_seed_ready", src_seed_ready, 1'b0);
      adv();
      mid();
      chk("seed_after_one_drain", src_seed_ready, 1'b1);
      chk("seed_count_hold", 80'(enc_count), 80'd3);
      adv();
      do_seed(80'hABCD_0000_1111);

      // Busy core holds DRAIN; an offered seed must not leak through.
      acc_q.push_back(0); acc_q.push_back(1); acc_q.push_back(2);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid();
         adv();
      end
      core_busy      = 1'b1;
      src_seed       = 80'h77;
      src_seed_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         mid();
         if (need_reseed !== 1'b1 || src_seed_ready !== 1'b0 || core_seed_valid !== 1'b0 || in_ready !== 1'b0) bad++;
         adv();
      end
      chk("drain_busy_hold", 80'(bad), 80'd0);
      core_busy      = 1'b0;
      src_seed_valid = 1'b0;
      in_valid       = 1'b0;
      mid();
      chk("drain_last_cycle", src_seed_ready, 1'b0);
      adv();
      mid();
      chk("seed_after_busy", src_seed_ready, 1'b1);
      adv();

      // Stalled seed: valid and data held steady, handshake on the sixth cycle.
      src_seed        = 80'hDEAD_BEEF_CAFE_0123_4567;
      src_seed_valid  = 1'b1;
      core_seed_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         mid();
         if (core_seed_valid !== 1'b1 || core_seed !== 80'hDEAD_BEEF_CAFE_0123_4567 || src_seed_ready !== 1'b0) bad++;
         adv();
      end
      chk("seed_stall_hold", 80'(bad), 80'd0);
      seed_q.push_back(80'hDEAD_BEEF_CAFE_0123_4567);
      core_seed_ready = 1'b1;
      mid();
      adv();
      src_seed_valid = 1'b0;
      mid();
      chk("stall_seed_run", need_reseed, 1'b0);
      adv();

      // Reset during a busy DRAIN returns to SEED with a zero count.
      acc_q.push_back(0); acc_q.push_back(1); acc_q.push_back(2);
      in_valid  = 1'b1;
      core_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mid();
         adv();
      end
      mid();
      chk("drain_busy_state", src_seed_ready, 1'b0);
      adv();
      rst = 1'b1;
      mid();
      adv();
      rst = 1'b0;
      mid();
      chk("rst_drain_count", 80'(enc_count), 80'd0);
      chk("rst_drain_need", need_reseed, 1'b1);
      chk("rst_drain_in_ready", in_ready, 1'b0);
      chk("rst_drain_seed_rdy", src_seed_ready, 1'b1);
      adv();

      // Reset wins over a seed handshake in the same cycle.
      seed_q.push_back(80'h55);
      src_seed       = 80'h55;
      src_seed_valid = 1'b1;
      in_valid       = 1'b0;
      rst            = 1'b1;
      mid();
      adv();
      rst            = 1'b0;
      src_seed_valid = 1'b0;
      mid();
      chk("rst_ignores_seed", need_reseed, 1'b1);
      adv();
      core_busy = 1'b0;
      do_seed(80'h9999);

`ifdef AES_RESEED_FORCE_EN
      // Forced reseed with a simultaneous accept: the accept still counts.
      acc_q.push_back(0);
      in_valid = 1'b1;
      mid();
      adv();
      in_valid = 1'b0;
      mid();
      chk("force_pre_count", 80'(enc_count), 80'd1);
      adv();
      acc_q.push_back(1);
      in_valid     = 1'b1;
      force_reseed = 1'b1;
      mid();
      adv();
      force_reseed = 1'b0;
      in_valid     = 1'b0;
      mid();
      chk("force_count", 80'(enc_count), 80'd2);
      chk("force_drain", need_reseed, 1'b1);
      adv();
`endif

      chk("seed_queue_empty", 80'(seed_q.size()), 80'd0);
      chk("accept_queue_empty", 80'(acc_q.size()), 80'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
